// File: rtl/clb_cfg_chain_if.sv
// Logic-input and config-chain signal bundle for one CLB tile.
// Master drives logic inputs and the chain input. Slave returns chain output, done flag and X/Y.
interface clb_cfg_chain_if #(
  parameter int N_IN = 4
) ();
  logic [N_IN-1:0] IN;
  logic            CFG_EN;
  logic            CFG_DIN;
  logic            CFG_DOUT;
  logic            CFG_DONE;
  logic            X;
  logic            Y;

  modport master (
    output IN, CFG_EN, CFG_DIN,
    input  CFG_DOUT, CFG_DONE, X, Y
  );

  modport slave (
    input  IN, CFG_EN, CFG_DIN,
    output CFG_DOUT, CFG_DONE, X, Y
  );
endinterface

// File: rtl/clb_cfg_chain.sv
// CLB with serial config chain: F/G LUTs, one set/reset/enable flop, X/Y muxes.
// LUTs and muxes are zero latency and the flop adds one cycle; no backpressure, the chain shifts whenever CFG_EN=1.
module clb_cfg_chain #(
  parameter int N_IN = 4
) (
  input  logic           K,
  input  logic           RST,
  clb_cfg_chain_if.slave bus
);
  localparam int LUT_SZ  = 2**N_IN;
  localparam int CFG_LEN = 2*LUT_SZ + 12;
  localparam int CNT_W   = $clog2(CFG_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CFG_LEN-1:0]   cfg_q, cfg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 q_q, q_d;

  logic                 fb_sel;
  logic [1:0]           y_sel, x_sel, r_sel, s_sel, ce_sel;
  logic [LUT_SZ-1:0]    lutf, lutg;
  logic                 q_init_unused;
  logic [N_IN-1:0]      addr;
  logic                 f_val, g_val;
  logic                 s_src, r_src, ce_src;
  logic                 last_shift;
  logic                 done_w, x_w, y_w;

  // Q_INIT is only consumed as CFG_DIN on the final shift, never from cfg_q.
  assign q_init_unused = cfg_q[0];
  assign fb_sel        = cfg_q[1];
  assign y_sel         = cfg_q[3:2];
  assign x_sel         = cfg_q[5:4];
  assign r_sel         = cfg_q[7:6];
  assign s_sel         = cfg_q[9:8];
  assign ce_sel        = cfg_q[11:10];
  assign lutg          = cfg_q[12 +: LUT_SZ];
  assign lutf          = cfg_q[12+LUT_SZ +: LUT_SZ];

  // Feedback only taps registered Q, so F/G never loop combinationally.
  assign addr  = {bus.IN[N_IN-1:1], (fb_sel ? q_q : bus.IN[0])};
  assign f_val = lutf[addr];
  assign g_val = lutg[addr];

  always_comb begin
    s_src  = 1'b0;
    r_src  = 1'b0;
    ce_src = 1'b0;
    case (s_sel)
      2'b00:   s_src = bus.IN[N_IN-1];
      2'b01:   s_src = f_val;
      default: s_src = 1'b0;
    endcase
    case (r_sel)
      2'b00:   r_src = bus.IN[0];
      2'b01:   r_src = g_val;
      default: r_src = 1'b0;
    endcase
    case (ce_sel)
      2'b00:   ce_src = 1'b1;
      2'b01:   ce_src = g_val;
      2'b10:   ce_src = bus.IN[1];
      default: ce_src = 1'b0;
    endcase
  end

  assign last_shift = (state_q == LOAD) && bus.CFG_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge K) begin
    if (RST) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cfg_d   = bus.CFG_EN ? {cfg_q[CFG_LEN-2:0], bus.CFG_DIN} : cfg_q;
    case (state_q)
      IDLE: begin
        q_d = 1'b0;
        if (bus.CFG_EN) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
        end
      end
      LOAD: begin
        q_d = 1'b0;
        if (last_shift) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          q_d     = bus.CFG_DIN;
        end else if (bus.CFG_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (bus.CFG_EN) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
          q_d     = 1'b0;
        end else if (ce_src) begin
          // Reset wins over set.
          q_d = r_src ? 1'b0 : (s_src ? 1'b1 : f_val);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
  end

  always_comb begin
    done_w = (state_q == ACTIVE);
    x_w    = 1'b0;
    y_w    = 1'b0;
    if (done_w) begin
      case (x_sel)
        2'b00:   x_w = f_val;
        2'b01:   x_w = g_val;
        default: x_w = q_q;
      endcase
      case (y_sel)
        2'b00:   y_w = q_q;
        2'b01:   y_w = g_val;
        default: y_w = f_val;
      endcase
    end
  end

  assign bus.CFG_DOUT = cfg_q[CFG_LEN-1];
  assign bus.CFG_DONE = done_w;
  assign bus.X        = x_w;
  assign bus.Y        = y_w;
endmodule

// File: tb/tb_clb_cfg_chain.sv
// Bench for clb_cfg_chain: directed scenarios plus random loads, checked each cycle against a bit-history model.
module tb_clb_cfg_chain;
  localparam int N_IN    = 4;
  localparam int CFG_LEN = 44;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clb_cfg_chain_if #(.N_IN(N_IN)) bus ();
  clb_cfg_chain #(.N_IN(N_IN)) u_dut (.K(clk), .RST(rst), .bus(bus));

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  // Model: every bit shifted since reset (newest at back), bits since load start, active flag, Q.
  logic hist[$];
  int   m_cnt    = 0;
  logic m_active = 1'b0;
  logic mq       = 1'b0;

  localparam logic [43:0] W2  = {16'h0116, 16'h0000, 12'h000};
  localparam logic [43:0] W3  = {16'h0116, 16'h0000, 12'h0A0};
  localparam logic [43:0] W4B = {16'h0116, 16'h0000, 12'h801};
  localparam logic [43:0] W5  = {16'hA5C3, 16'h3C5A, 12'hC01};

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CFG_LEN-1:0] m_cfg();
    logic [CFG_LEN-1:0] c;
    for (int i = 0; i < CFG_LEN; i++)
      c[i] = (i < hist.size()) ? hist[hist.size()-1-i] : 1'b0;
    return c;
  endfunction

  task automatic m_eval(input logic [3:0] in, output logic f, output logic s, output logic r,
                        output logic ce, output logic x, output logic y, output logic dout);
    logic [CFG_LEN-1:0] c;
    logic [15:0] lf, lg;
    logic [3:0]  a;
    logic        g;
    c  = m_cfg();
    lf = c[43:28];
    lg = c[27:12];
    a  = c[1] ? {in[3:1], mq} : in;
    f  = lf[a];
    g  = lg[a];
    s  = (c[9:8] == 2'b00) ? in[3] : (c[9:8] == 2'b01) ? f : 1'b0;
    r  = (c[7:6] == 2'b00) ? in[0] : (c[7:6] == 2'b01) ? g : 1'b0;
    case (c[11:10])
      2'b00:   ce = 1'b1;
      2'b01:   ce = g;
      2'b10:   ce = in[1];
      default: ce = 1'b0;
    endcase
    x    = !m_active ? 1'b0 : (c[5:4] == 2'b00) ? f : (c[5:4] == 2'b01) ? g : mq;
    y    = !m_active ? 1'b0 : (c[3:2] == 2'b00) ? mq : (c[3:2] == 2'b01) ? g : f;
    dout = c[CFG_LEN-1];
  endtask

  always @(posedge clk) begin
    logic f, s, r, ce, x, y, d;
    if (rst) begin
      hist.delete();
      m_cnt    = 0;
      m_active = 1'b0;
      mq       = 1'b0;
    end else begin
      m_eval(bus.IN, f, s, r, ce, x, y, d);
      if (m_active && !bus.CFG_EN && ce)
        mq = r ? 1'b0 : (s ? 1'b1 : f);
      if (bus.CFG_EN) begin
        hist.push_back(bus.CFG_DIN);
        if (hist.size() > CFG_LEN) void'(hist.pop_front());
        if (m_active) begin
          m_active = 1'b0;
          m_cnt    = 1;
          mq       = 1'b0;
        end else begin
          m_cnt++;
          if (m_cnt == CFG_LEN) begin
            m_active = 1'b1;
            m_cnt    = 0;
            mq       = bus.CFG_DIN;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic f, s, r, ce, x, y, d;
    if (chk_en) begin
      m_eval(bus.IN, f, s, r, ce, x, y, d);
      chk("cyc_done", bus.CFG_DONE, m_active);
      chk("cyc_x", bus.X, x);
      chk("cyc_y", bus.Y, y);
      chk("cyc_dout", bus.CFG_DOUT, d);
    end
  end

  // sel: 0 CFG_DONE, 1 X, 2 Y, 3 CFG_DOUT; pins both the DUT and the model to a literal.
  task automatic pin(input string nm, input int sel, input logic exp);
    logic f, s, r, ce, x, y, d, dv, mv;
    m_eval(bus.IN, f, s, r, ce, x, y, d);
    case (sel)
      0:       begin dv = bus.CFG_DONE; mv = m_active; end
      1:       begin dv = bus.X;        mv = x;        end
      2:       begin dv = bus.Y;        mv = y;        end
      default: begin dv = bus.CFG_DOUT; mv = d;        end
    endcase
    chk({nm, "_dut"}, dv, exp);
    chk({nm, "_model"}, mv, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.CFG_EN = 1'b0;
    repeat (n) tick();
  endtask

  task automatic shift_bit(input logic b);
    bus.CFG_EN  = 1'b1;
    bus.CFG_DIN = b;
    tick();
    bus.CFG_EN  = 1'b0;
  endtask

  task automatic load(input logic [43:0] w);
    for (int i = CFG_LEN-1; i >= 0; i--) shift_bit(w[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rw;
    logic [43:0] w;
    bus.IN      = '0;
    bus.CFG_EN  = 1'b0;
    bus.CFG_DIN = 1'b0;
    rst         = 1'b1;
    tick();
    bus.CFG_EN  = 1'b1;
    bus.CFG_DIN = 1'b1;
    tick();
    rst        = 1'b0;
    bus.CFG_EN = 1'b0;
    chk_en     = 1'b1;

    // Reset state; IN toggling has no effect.
    pin("rst_done", 0, 1'b0);
    pin("rst_x", 1, 1'b0);
    pin("rst_y", 2, 1'b0);
    pin("rst_dout", 3, 1'b0);
    for (int v = 1; v < 16; v += 5) begin
      bus.IN = 4'(v);
      tick();
      pin("rst_in_x", 1, 1'b0);
      pin("rst_in_y", 2, 1'b0);
    end

    // LUT lookup through X.
    for (int i = CFG_LEN-1; i >= 1; i--) shift_bit(W2[i]);
    pin("t2_done_43", 0, 1'b0);
    shift_bit(W2[0]);
    pin("t2_done_44", 0, 1'b1);
    bus.IN = 4'b0001; #1;
    pin("t2_x_0001", 1, 1'b1);
    bus.IN = 4'b0011; #1;
    pin("t2_x_0011", 1, 1'b0);

    // Flop D path through Y.
    load(W3);
    bus.IN = 4'b0001; tick();
    pin("t3_y_set", 2, 1'b1);
    bus.IN = 4'b0011; tick();
    pin("t3_y_clr", 2, 1'b0);

    // Reset beats set, then clock enable from IN[1].
    load(W2);
    bus.IN = 4'b1001; tick();
    pin("t4_r_wins", 2, 1'b0);
    bus.IN = 4'b1000; tick();
    pin("t4_s", 2, 1'b1);
    load(W4B);
    pin("t4_qinit", 2, 1'b1);
    bus.IN = 4'b1001; tick(); tick();
    pin("t4_ce_hold", 2, 1'b1);
    bus.IN = 4'b1011; tick();
    pin("t4_ce_on", 2, 1'b0);

    // Reconfiguration from ACTIVE with a pause at bit 20.
    shift_bit(W5[43]);
    pin("t5_done_drop", 0, 1'b0);
    pin("t5_x_drop", 1, 1'b0);
    pin("t5_y_drop", 2, 1'b0);
    pin("t5_dout_1", 3, W4B[42]);
    for (int k = 2; k <= 10; k++) begin
      shift_bit(W5[44-k]);
      pin("t5_dout_k", 3, W4B[43-k]);
    end
    for (int i = 33; i >= 24; i--) shift_bit(W5[i]);
    for (int p = 0; p < 5; p++) begin
      idle(1);
      pin("t5_pause", 0, 1'b0);
    end
    for (int i = 23; i >= 1; i--) shift_bit(W5[i]);
    pin("t5_done_43", 0, 1'b0);
    shift_bit(W5[0]);
    pin("t5_done_44", 0, 1'b1);
    pin("t5_q_init", 2, 1'b1);
    idle(3);
    pin("t5_frozen", 2, 1'b1);

    // Reset mid-load.
    for (int i = CFG_LEN-1; i >= 14; i--) shift_bit(W5[i]);
    rst = 1'b1; tick(); rst = 1'b0;
    pin("t6_done", 0, 1'b0);
    pin("t6_dout", 3, 1'b0);
    for (int i = CFG_LEN-1; i >= 1; i--) shift_bit(W2[i]);
    pin("t6_done_43", 0, 1'b0);
    shift_bit(W2[0]);
    pin("t6_done_44", 0, 1'b1);
    bus.IN = 4'b0001; #1;
    pin("t6_x", 1, 1'b1);

    // Random words, random pauses, occasional reset mid-load, random IN while active.
    for (int it = 0; it < 24; it++) begin
      rw = {$urandom(), $urandom()};
      w  = rw[43:0];
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 40)); i++) shift_bit(1'($urandom_range(0, 1)));
        rst = 1'b1; tick(); rst = 1'b0;
      end
      for (int i = CFG_LEN-1; i >= 0; ) begin
        bus.IN = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) begin
          shift_bit(w[i]);
          i--;
        end else begin
          idle(1);
        end
      end
      for (int c = 0; c < 30; c++) begin
        bus.IN = 4'($urandom_range(0, 15));
        tick();
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
